// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO controller: address width, register
// offsets and the bus handshake state encoding.
package gpio_pkg;

    localparam int unsigned ADDR_W = 5;

    localparam logic [ADDR_W-1:0] GPIO_DOUT   = 5'h00;
    localparam logic [ADDR_W-1:0] GPIO_DIR    = 5'h04;
    localparam logic [ADDR_W-1:0] GPIO_DIN    = 5'h08;
    localparam logic [ADDR_W-1:0] GPIO_IE     = 5'h0C;
    localparam logic [ADDR_W-1:0] GPIO_RISE   = 5'h10;
    localparam logic [ADDR_W-1:0] GPIO_FALL   = 5'h14;
    localparam logic [ADDR_W-1:0] GPIO_STATUS = 5'h18;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } bus_state_t;

endpackage

// File: rtl/gpio_sync.sv
// Multi-stage flop synchroniser for asynchronous pad inputs; the chain
// clears to zero on reset.
module gpio_sync #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] chain [STAGES];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chain <= '{default: '0};
        end else begin
            chain[0] <= din;
            for (int unsigned i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign dout = chain[STAGES-1];

endmodule

// File: rtl/gpio_ctrl.sv
// Memory-mapped GPIO controller: pad drive registers, synchronised
// readback, edge-detect status with W1C clear and a level interrupt.
module gpio_ctrl
    import gpio_pkg::*;
#(
    parameter int unsigned NUM_GPIO    = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                sel_i,
    input  logic                we_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [31:0]         wdata_i,
    output logic [31:0]         rdata_o,
    output logic                ack_o,
    output logic [NUM_GPIO-1:0] gpio_oe,
    output logic [NUM_GPIO-1:0] gpio_out,
    input  logic [NUM_GPIO-1:0] gpio_in,
    output logic                irq_o
);

    bus_state_t          state;
    logic [NUM_GPIO-1:0] dout, dir, ie, rise_en, fall_en, status;
    logic [NUM_GPIO-1:0] din_s, din_d;
    logic [NUM_GPIO-1:0] evt, w1c, wmask;
    logic [ADDR_W-1:0]   word_addr;
    logic [31:0]         rd_mux;
    logic                wr_en, irq;
    logic                unused_bits;

    assign unused_bits = ^{addr_i[1:0], wdata_i};

    gpio_sync #(
        .WIDTH  (NUM_GPIO),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (gpio_in),
        .dout    (din_s)
    );

    assign word_addr = {addr_i[ADDR_W-1:2], 2'b00};
    assign wr_en     = (state == ST_IDLE) && sel_i && we_i;
    assign wmask     = wdata_i[NUM_GPIO-1:0];

    always_comb begin
        rd_mux = '0;
        case (word_addr)
            GPIO_DOUT:   rd_mux = 32'(dout);
            GPIO_DIR:    rd_mux = 32'(dir);
            GPIO_DIN:    rd_mux = 32'(din_s);
            GPIO_IE:     rd_mux = 32'(ie);
            GPIO_RISE:   rd_mux = 32'(rise_en);
            GPIO_FALL:   rd_mux = 32'(fall_en);
            GPIO_STATUS: rd_mux = 32'(status);
            default:     rd_mux = '0;
        endcase
    end

    // New events are OR-ed in after the clear so a same-cycle event wins.
    assign evt = (din_s & ~din_d & rise_en) | (~din_s & din_d & fall_en);
    assign w1c = (wr_en && word_addr == GPIO_STATUS) ? wmask : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            ack_o   <= 1'b0;
            rdata_o <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (sel_i) begin
                        state   <= ST_ACK;
                        ack_o   <= 1'b1;
                        rdata_o <= we_i ? '0 : rd_mux;
                    end else begin
                        ack_o   <= 1'b0;
                        rdata_o <= '0;
                    end
                end
                ST_ACK: begin
                    state   <= ST_IDLE;
                    ack_o   <= 1'b0;
                    rdata_o <= '0;
                end
                default: begin
                    state   <= ST_IDLE;
                    ack_o   <= 1'b0;
                    rdata_o <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dout    <= '0;
            dir     <= '0;
            ie      <= '0;
            rise_en <= '0;
            fall_en <= '0;
            status  <= '0;
            din_d   <= '0;
            irq     <= 1'b0;
        end else begin
            din_d  <= din_s;
            status <= (status & ~w1c) | evt;
            irq    <= |(status & ie);
            if (wr_en) begin
                case (word_addr)
                    GPIO_DOUT: dout    <= wmask;
                    GPIO_DIR:  dir     <= wmask;
                    GPIO_IE:   ie      <= wmask;
                    GPIO_RISE: rise_en <= wmask;
                    GPIO_FALL: fall_en <= wmask;
                    default:   ;
                endcase
            end
        end
    end

    assign gpio_oe  = dir;
    assign gpio_out = dout;
    assign irq_o    = irq;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Directed self-checking bench for gpio_ctrl with a simple pad model:
// driven pins read back their own level, others follow ext.
module tb_gpio_ctrl;
    import gpio_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sel_i = 1'b0;
    logic        we_i = 1'b0;
    logic [4:0]  addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic [31:0] rdata_o;
    logic        ack_o;
    logic [7:0]  gpio_oe, gpio_out, gpio_in;
    logic        irq_o;
    logic [7:0]  ext = '0;
    logic [31:0] rd;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clk = ~clk;

    assign gpio_in = (gpio_oe & gpio_out) | (~gpio_oe & ext);

    gpio_ctrl #(
        .NUM_GPIO    (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .sel_i    (sel_i),
        .we_i     (we_i),
        .addr_i   (addr_i),
        .wdata_i  (wdata_i),
        .rdata_o  (rdata_o),
        .ack_o    (ack_o),
        .gpio_oe  (gpio_oe),
        .gpio_out (gpio_out),
        .gpio_in  (gpio_in),
        .irq_o    (irq_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        sel_i = 1'b1; we_i = 1'b1; addr_i = a; wdata_i = d;
        @(negedge clk);
        sel_i = 1'b0; we_i = 1'b0;
        check("wr_ack", 32'(ack_o), 32'd1);
    endtask

    task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
        @(negedge clk);
        sel_i = 1'b1; we_i = 1'b0; addr_i = a;
        @(negedge clk);
        sel_i = 1'b0;
        check("rd_ack_hi", 32'(ack_o), 32'd1);
        d = rdata_o;
        @(negedge clk);
        check("rd_ack_lo", 32'(ack_o), 32'd0);
        check("rd_zero_after_ack", rdata_o, 32'd0);
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        // Reset state and every offset reads zero
        wait_cycles(3);
        check("rst_oe", 32'(gpio_oe), 32'h0);
        check("rst_out", 32'(gpio_out), 32'h0);
        check("rst_irq", 32'(irq_o), 32'h0);
        check("rst_ack", 32'(ack_o), 32'h0);
        reset_n = 1'b1;
        wait_cycles(2);
        for (int i = 0; i < 8; i++) begin
            bus_read(5'(i * 4), rd);
            check("rst_read", rd, 32'h0);
        end

        // Pad drive and readback through the pad model
        ext = 8'h30;
        bus_write(GPIO_DIR, 32'h0F);
        bus_write(GPIO_DOUT, 32'hA5);
        check("oe_0f", 32'(gpio_oe), 32'h0F);
        check("out_a5", 32'(gpio_out), 32'hA5);
        wait_cycles(4);
        bus_read(GPIO_DIN, rd);
        check("din_mixed", rd, 32'h35);

        // Unmapped write is dropped, DIN write ignored
        bus_write(5'h1C, 32'hFF);
        bus_write(GPIO_DIN, 32'hFF);
        bus_read(GPIO_DIN, rd);
        check("din_ro", rd, 32'h35);

        // Synchroniser latency
        bus_write(GPIO_DIR, 32'h00);
        bus_write(GPIO_DOUT, 32'h00);
        ext = 8'h00;
        wait_cycles(4);
        @(negedge clk);
        ext = 8'h01;
        bus_read(GPIO_DIN, rd);
        check("din_early", rd, 32'h00);
        ext = 8'h00;
        wait_cycles(4);
        @(negedge clk);
        ext = 8'h01;
        @(negedge clk);
        bus_read(GPIO_DIN, rd);
        check("din_latency", rd, 32'h01);

        // Rising edge interrupt and W1C
        ext = 8'h00;
        wait_cycles(4);
        bus_write(GPIO_RISE, 32'h01);
        bus_write(GPIO_IE, 32'h01);
        check("irq_idle", 32'(irq_o), 32'h0);
        @(negedge clk);
        ext = 8'h01;
        wait_cycles(5);
        bus_read(GPIO_STATUS, rd);
        check("status_rise", rd, 32'h01);
        check("irq_set", 32'(irq_o), 32'h1);
        bus_write(GPIO_STATUS, 32'h01);
        check("irq_hold", 32'(irq_o), 32'h1);
        @(negedge clk);
        check("irq_drop", 32'(irq_o), 32'h0);
        bus_read(GPIO_STATUS, rd);
        check("status_clr", rd, 32'h00);
        ext = 8'h00;
        wait_cycles(5);
        bus_read(GPIO_STATUS, rd);
        check("status_no_fall", rd, 32'h00);
        check("irq_no_fall", 32'(irq_o), 32'h0);

        // Event beats same-cycle W1C; W1C of another bit still clears it
        bus_write(GPIO_FALL, 32'h02);
        @(negedge clk);
        ext = 8'h03;
        wait_cycles(5);
        bus_read(GPIO_STATUS, rd);
        check("status_pre", rd, 32'h01);
        @(negedge clk);
        ext = 8'h01;
        @(negedge clk);
        bus_write(GPIO_STATUS, 32'h03);
        wait_cycles(2);
        bus_read(GPIO_STATUS, rd);
        check("status_evt_wins", rd, 32'h02);
        check("irq_masked", 32'(irq_o), 32'h0);

        // Reset during a write transaction
        bus_write(GPIO_DIR, 32'hFF);
        check("oe_ff", 32'(gpio_oe), 32'hFF);
        @(negedge clk);
        sel_i = 1'b1; we_i = 1'b1; addr_i = GPIO_DOUT; wdata_i = 32'h5A;
        #1 reset_n = 1'b0;
        #1 check("oe_async_clr", 32'(gpio_oe), 32'h00);
        @(posedge clk);
        #1 check("no_ack_in_rst", 32'(ack_o), 32'h0);
        @(negedge clk);
        sel_i = 1'b0; we_i = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        check("no_ack_after", 32'(ack_o), 32'h0);
        check("out_discarded", 32'(gpio_out), 32'h00);
        bus_read(GPIO_DIR, rd);
        check("dir_after_rst", rd, 32'h00);
        bus_read(GPIO_DOUT, rd);
        check("dout_after_rst", rd, 32'h00);
        bus_read(GPIO_FALL, rd);
        check("fall_after_rst", rd, 32'h00);
        bus_read(GPIO_STATUS, rd);
        check("status_after_rst", rd, 32'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/gpio_ctrl.md
Name: gpio_ctrl

Overview:
- Memory-mapped GPIO controller for the rv32i SoC peripheral bus.
- Owns the per-pin output-enable and output-data registers that drive the bidirectional pad cells.
- Synchronises pad readback and detects edges for interrupts.
- Sits beside the UART/SPI peripherals; pad cells are instantiated one per pin at top level and wired to gpio_oe/gpio_out/gpio_in.

Parameters:
- NUM_GPIO, 8, number of pins (1..32); register bits above NUM_GPIO-1 read 0 and ignore writes.
- SYNC_STAGES, 2, input synchroniser depth (≥2).

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- sel_i  input  1  bus access request, one-cycle pulse per transaction.
- we_i  input  1  1 = write, 0 = read.
- addr_i  input  5  byte address; [1:0] ignored.
- wdata_i  input  32  write data.
- rdata_o  output  32  read data, valid while ack_o = 1.
- ack_o  output  1  transaction complete.
- gpio_oe  output  NUM_GPIO  per-pin output enable to the pad cell.
- gpio_out  output  NUM_GPIO  per-pin drive value to the pad cell.
- gpio_in  input  NUM_GPIO  raw pad readback, asynchronous.
- irq_o  output  1  level interrupt to the core.

Behaviour:
- Reset (async, reset_n low): all registers 0. gpio_oe=0 (all pins high-Z), gpio_out=0, rdata_o=0, ack_o=0, irq_o=0. The synchroniser chain clears to 0.
- Register map, word offsets (gpio_pkg):
  - 0x00 DOUT: RW.
  - 0x04 DIR: RW, 1 = output.
  - 0x08 DIN: RO, synchronised input; writes ignored.
  - 0x0C IE: RW, per-pin interrupt enable.
  - 0x10 RISE: RW, 1 = detect rising edge.
  - 0x14 FALL: RW, 1 = detect falling edge.
  - 0x18 STATUS: read returns pending bits; write-1-to-clear.
  - Unmapped offsets: reads return 0, writes are dropped, and ack is still given.
- Bus handshake: 2-state FSM, IDLE→ACK→IDLE.
  - sel_i sampled in IDLE moves the FSM to ACK.
  - ack_o=1 for exactly one cycle, the cycle after sel_i.
  - The write takes effect on the sel_i edge.
  - rdata_o is registered on the sel_i edge, held during ack, and zeroed otherwise.
  - sel_i asserted during ACK is ignored; the master must not issue back-to-back requests without waiting for ack.
- Pad drive: gpio_oe=DIR and gpio_out=DOUT, both directly from flops.
- Input path: gpio_in passes through a SYNC_STAGES flop chain to produce din_s, then one more flop din_d. DIN reads din_s. With 2 stages, a pad change is visible in DIN 2 clocks later.
- Edge detect:
  - rise = din_s & ~din_d; fall = ~din_s & din_d.
  - evt = (rise & RISE) | (fall & FALL).
  - STATUS |= evt each cycle.
- Output pins read back their own driven level through the pad, so they can generate events; this is intended and lets firmware self-test.
- irq_o = |(STATUS & IE), registered (one cycle after STATUS updates).
- Simultaneous events:
  - A W1C and a new event on the same bit in the same cycle: the event wins and the bit stays 1.
  - W1C on other bits does not disturb a new event.
- Changing DIR or RISE/FALL mid-operation has no retroactive effect; already-pending STATUS bits persist.
- reset_n asserted mid-transaction: FSM returns to IDLE, no ack, and the pending write is discarded.

Decomposition:
- gpio_pkg holds the register offset localparams (GPIO_DOUT..GPIO_STATUS), the bus FSM state enum typedef (ST_IDLE, ST_ACK), and the address width.
- One sub-module, gpio_sync.
  - Parameterised width and stage count.
  - Async active-low reset.
  - Instanced once with width NUM_GPIO.
- Pad cells stay outside this block.

Test Plan:
- Reset, then read all offsets → every read returns 0. gpio_oe=0x00, irq_o=0, and each ack_o is exactly one cycle.
- Write DIR=0x0F, then DOUT=0xA5 → gpio_oe=0x0F and gpio_out=0xA5. With a pad model, DIN reads 0x05 on pins 3:0 (upper nibble follows the external stimulus).
- DIR=0 with gpio_in stepped 0x00→0x01 → DIN reads 0x01 starting 2 cycles after the change, and the same read 1 cycle earlier returns 0x00.
- RISE=0x01, IE=0x01, toggle pin0 0→1 → STATUS=0x01 and irq_o=1. Write STATUS=0x01 → STATUS=0 and irq_o drops the following cycle. A 1→0 toggle raises no interrupt.
- FALL=0x02, falling edge on pin1 in the same cycle as a write of 0x02 to STATUS → STATUS bit1 remains 1.
- Assert reset_n low for one cycle while DIR=0xFF, mid-transaction → gpio_oe goes to 0 immediately (asynchronously), no ack_o is issued, and registers read 0 afterwards.
